// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet transmit path arbiter:
//   - tx_state_t      : arbiter FSM states (IDLE, GRANT, IFG)
//   - DEFAULT_*       : default inter-frame gap and watchdog lengths
//   - REQ_ICMP/REQ_ARP: requester index assignments on the shared TX path
//   - min1_clog2      : ceil(log2(value)) clamped to at least 1 bit
// ---------------------------------------------------------------------------
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    IFG   = 2'd2
  } tx_state_t;

  localparam int DEFAULT_IFG_CYCLES = 12;
  localparam int DEFAULT_WDT_CYCLES = 2048;

  localparam int REQ_ICMP = 0;
  localparam int REQ_ARP  = 1;

  // Counter/index widths must never collapse to zero bits.
  function automatic int min1_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches upward from (i_last + 1) mod
// NUM_REQ, wrapping, and returns the first requester found.
// Ports:
//   i_req   in  NUM_REQ  level requests
//   i_last  in  IW       index granted most recently
//   o_grant out NUM_REQ  one-hot pick, all-zero when nothing is requested
//   o_idx   out IW       binary index of the pick
//   o_valid out 1        a requester was picked
// ---------------------------------------------------------------------------
module rr_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = min1_clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  // Offsets 1..NUM_REQ visit every index once, ending on i_last itself,
  // so the previous winner has the lowest priority.
  always_comb begin
    logic [IW-1:0] pos;
    pos     = '0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IW'((int'(i_last) + k) % NUM_REQ);
      if (!o_valid && i_req[pos]) begin
        o_valid      = 1'b1;
        o_grant[pos] = 1'b1;
        o_idx        = pos;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_arbiter
// Round-robin owner of the single Ethernet TX byte path. A protocol engine
// (0 = ICMP, 1 = ARP, ...) requests, keeps the grant for a whole frame,
// releases with a tx_done pulse, then IFG_CYCLES idle cycles are enforced.
// Optional feature macro: TX_WATCHDOG_EN -- releases a grant that has been
// held WDT_CYCLES cycles without tx_done and pulses wdt_abort.
// Ports:
//   aclk, areset       clock, asynchronous active-high reset
//   tx_req[N]          per-requester level request
//   tx_done[N]         per-requester end-of-frame pulse
//   tx_data[N*8]       per-requester byte, requester i on [8i+7:8i]
//   tx_valid[N]        per-requester byte qualifier
//   tx_grant[N]        one-hot grant, zero when idle
//   frame_start        pulse in the first grant cycle
//   data_out[8]        registered byte of the granted requester
//   data_valid         registered qualifier of data_out
//   busy               high while granted or in the inter-frame gap
//   wdt_abort          watchdog release pulse (0 without TX_WATCHDOG_EN)
// ---------------------------------------------------------------------------
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = DEFAULT_IFG_CYCLES,
  parameter int WDT_CYCLES = DEFAULT_WDT_CYCLES
)(
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [NUM_REQ-1:0]   tx_req,
  input  logic [NUM_REQ-1:0]   tx_done,
  input  logic [NUM_REQ*8-1:0] tx_data,
  input  logic [NUM_REQ-1:0]   tx_valid,
  output logic [NUM_REQ-1:0]   tx_grant,
  output logic                 frame_start,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 wdt_abort
);

  localparam int IW = min1_clog2(NUM_REQ);
  localparam int GW = min1_clog2(IFG_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  tx_state_t          r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_last;
  logic [GW-1:0]      r_gap;
  logic               r_frame_start;
  logic [7:0]         r_data_out;
  logic               r_data_valid;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic               w_done_hit;
  logic               w_wdt_expire;
  logic               w_release;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .i_req   (tx_req),
    .i_last  (r_last),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Only the owner's done closes the frame; stray pulses are ignored.
  assign w_done_hit = (r_state == GRANT) && tx_done[r_idx];
  assign w_release  = w_done_hit || w_wdt_expire;

`ifdef TX_WATCHDOG_EN
  localparam int WW = min1_clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] r_wdt;
  logic          r_wdt_abort;

  assign w_wdt_expire = (r_state == GRANT) && (r_wdt == WDT_LAST);

  // Grant-age counter: zero on entry to GRANT, so expiry lands exactly
  // WDT_CYCLES cycles after the grant appeared. A real done wins a tie.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wdt       <= '0;
      r_wdt_abort <= 1'b0;
    end else begin
      r_wdt_abort <= w_wdt_expire && !w_done_hit;
      if ((r_state == GRANT) && !w_release) begin
        r_wdt <= r_wdt + 1'b1;
      end else begin
        r_wdt <= '0;
      end
    end
  end

  assign wdt_abort = r_wdt_abort;
`else
  assign w_wdt_expire = 1'b0;
  assign wdt_abort    = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_idx         <= '0;
      r_last        <= IW'(NUM_REQ - 1);
      r_gap         <= '0;
      r_frame_start <= 1'b0;
      r_data_out    <= 8'h00;
      r_data_valid  <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_data_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant       <= w_pick_grant;
            r_idx         <= w_pick_idx;
            r_frame_start <= 1'b1;
            r_state       <= GRANT;
          end
        end
        GRANT: begin
          // The done cycle still carries the owner's last byte.
          r_data_out   <= tx_data[{r_idx, 3'b000} +: 8];
          r_data_valid <= tx_valid[r_idx];
          if (w_release) begin
            r_last  <= r_idx;
            r_grant <= '0;
            r_gap   <= '0;
            r_state <= (IFG_CYCLES == 0) ? IDLE : IFG;
          end
        end
        IFG: begin
          if (r_gap == GAP_LAST) begin
            r_gap   <= '0;
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_grant    = r_grant;
  assign frame_start = r_frame_start;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign busy        = (r_state != IDLE);

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Round-robin scheduler sharing the single Ethernet transmit byte path between protocol reply engines (ICMP echo reply, ARP reply, future UDP). Each engine requests the path, holds it for a whole frame once granted, and releases it with an end-of-frame pulse. The arbiter muxes the granted engine's byte stream onto the shared output and enforces an inter-frame gap. It sits between the protocol TX engines and the Ethernet header/MAC TX stage.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8); index 0 = ICMP, 1 = ARP
- IFG_CYCLES, 12, idle byte cycles inserted after each frame (0 allowed)
- WDT_CYCLES, 2048, watchdog limit in cycles (used only with TX_WATCHDOG_EN)

Ports:
- aclk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- tx_req  in  NUM_REQ  per-requester level request
- tx_done  in  NUM_REQ  per-requester single-cycle end-of-frame pulse
- tx_data  in  NUM_REQ*8  per-requester byte; requester i on bits [8i+7:8i]
- tx_valid  in  NUM_REQ  per-requester byte qualifier
- tx_grant  out  NUM_REQ  one-hot grant, all-zero when idle
- frame_start  out  1  single-cycle pulse in the first grant cycle
- data_out  out  8  muxed byte, registered
- data_valid  out  1  data_out qualifier, registered
- busy  out  1  high in GRANT and IFG
- wdt_abort  out  1  single-cycle pulse on watchdog release (tied 0 without macro)

## Operation
- FSM states: IDLE, GRANT, IFG.
- IDLE: if tx_req != 0, select the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping. Register the one-hot tx_grant, pulse frame_start, go to GRANT. If tx_req == 0, stay.
- GRANT: data_out <= granted tx_data byte; data_valid <= granted tx_valid. Grant is held regardless of tx_req; tx_req drop mid-frame is ignored. tx_done of the granted index: last_grant <= granted index, tx_grant clears next cycle, go to IFG (or IDLE if IFG_CYCLES == 0). tx_done on any non-granted index is ignored.
- IFG: gap counter counts IFG_CYCLES cycles; data_valid = 0; new requests are not granted; at count == IFG_CYCLES-1, counter clears, go to IDLE.
- last_grant resets to NUM_REQ-1, so index 0 wins the first arbitration.
- Non-granted tx_data/tx_valid never reach data_out.
- Gap counter width: $clog2(IFG_CYCLES+1), minimum 1.

## Timing
- Reset values: tx_grant 0, frame_start 0, data_out 8'h00, data_valid 0, busy 0, wdt_abort 0, FSM IDLE, gap/watchdog counters 0.
- tx_req sampled high in IDLE at cycle N -> tx_grant and frame_start at N+1.
- Byte presented by granted requester at cycle M -> data_out/data_valid at M+1.
- tx_done at cycle D -> tx_grant = 0 from D+1; earliest next grant at D+1+IFG_CYCLES+1 (D+2 when IFG_CYCLES = 0).
- Simultaneous tx_done and tx_req from the same requester: frame closes; the request re-arbitrates after the gap with rotated priority.
- areset asserted mid-frame: all outputs drop immediately (asynchronously); no done or abort pulse is generated.

## Configuration
- TX_WATCHDOG_EN defined: a cycle counter runs in GRANT, clears on entry. Reaching WDT_CYCLES without tx_done forces release: wdt_abort pulses, last_grant updates, go to IFG. Same path as tx_done.
- Undefined: no watchdog counter; wdt_abort tied 0; grant held until tx_done indefinitely.

## Structure
- eth_pkg: FSM state enum (IDLE, GRANT, IFG), default IFG/WDT constants, requester index constants (REQ_ICMP = 0, REQ_ARP = 1).
- Sub-module rr_arbiter: combinational round-robin pick (tx_req, last_grant -> one-hot, valid). FSM, mux and counters stay in eth_tx_arbiter.

## Test plan
- Single request: tx_req = 01 at cycle 5 -> tx_grant = 01 and frame_start at 6; bytes AA,BB at 7,8 -> data_out AA,BB at 8,9; tx_done at 9 -> grant 0 at 10; busy low after 12 gap cycles.
- Contention: tx_req = 11 held continuously -> grants alternate 01, 10, 01; each grant is separated by 12 idle cycles.
- Stray done: tx_done[1] pulses while index 0 is granted -> no state change, grant stays 01.
- Request drop: index 0 granted, tx_req[0] falls mid-frame -> grant held until tx_done[0].
- Reset mid-frame: areset pulsed while data_valid = 1 -> all outputs 0 same cycle; next request from index 1 alone is granted normally.
- TX_WATCHDOG_EN, WDT_CYCLES = 16: grant without tx_done -> wdt_abort pulses and grant clears 16 cycles after grant.
